// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port synchronous data memory between two requesters:
//   port 0 (CPU load/store unit) and port 1 (DMA/debug loader). At most one
//   access is granted per cycle. Read data returns to the issuing port exactly
//   one cycle after acceptance. Back-to-back reads are fully pipelined.
//
// Parameters
//   ADDR_W    word-address width (must match the memory)
//   MAX_WAIT  consecutive cycles port 1 may be denied before it is forced to win
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   pK_req/we/addr/wdata (K = 0,1)     request, write/read, word address, write data
//   pK_gnt                             request accepted this cycle (combinational)
//   pK_rvalid/rdata                    read response (rdata is 0 when !rvalid)
//   mem_we/addr/wdata                  to memory (all 0 when nothing is granted)
//   mem_rdata                          from memory, registered, 1-cycle latency
//
// Configuration
//   DMEM_ARB_RR_EN  defined: round-robin between the two ports on contention,
//                   using a last-grant pointer; MAX_WAIT is ignored.
//                   undefined: port 0 has priority, and port 1 is forced to win
//                   after MAX_WAIT consecutive denied cycles.

module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    logic p1_win;
    logic rpend;
    logic rtag;

`ifdef DMEM_ARB_RR_EN
    // Port that won the most recent accepted transfer; 1 at reset so that
    // port 0 wins the first contended cycle.
    logic last;

    assign p1_win = p1_req && (!p0_req || !last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (p0_gnt || p1_gnt) begin
            last <= p1_gnt;
        end
    end
`else
    localparam int unsigned       CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WAIT);

    // Consecutive cycles port 1 has been waiting while requesting.
    logic [CNT_W-1:0] starve_cnt;

    assign p1_win = p1_req && (!p0_req || (starve_cnt == CNT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!p1_req || p1_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        p0_gnt    = p0_req && !p1_win;
        p1_gnt    = p1_win;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (p0_gnt) begin
            mem_we    = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else if (p1_gnt) begin
            mem_we    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end
    end

    // Read-return tag: the memory answers one cycle after the accepted read,
    // so only the issuing port and a pending flag need to be remembered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpend <= 1'b0;
            rtag  <= 1'b0;
        end else begin
            rpend <= (p0_gnt && !p0_we) || (p1_gnt && !p1_we);
            rtag  <= p1_gnt;
        end
    end

    always_comb begin
        p0_rvalid = rpend && !rtag;
        p1_rvalid = rpend && rtag;
        p0_rdata  = p0_rvalid ? mem_rdata : '0;
        p1_rdata  = p1_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Bench for dmem_arbiter with a behavioural 32-word synchronous memory.
//   A driver issues directed and random requests, predicts grants from the
//   arbitration rules and queues expected read responses; a separate monitor
//   pops the queue whenever a read response appears.

module tb_dmem_arbiter;

    localparam int AW = 5;
    localparam int MW = 4;

    logic        clk;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    dmem_arbiter #(.ADDR_W(AW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return (i == 7) ? 32'h12345678 : (32'hA5000000 | i);
    endfunction

    // Memory: registered read (old data on simultaneous write).
    logic        preload;
    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } resp_t;
    resp_t q[$];

    // Reference state: memory contents as seen by accepted transfers,
    // port 1's consecutive denial count, and the last winner.
    logic [31:0] shadow [32];
    int          m_denied;
    int          m_last;

    function automatic int pick(logic r0, logic r1);
        if (r0 && r1) begin
`ifdef DMEM_ARB_RR_EN
            return (m_last == 1) ? 0 : 1;
`else
            return (m_denied >= MW) ? 1 : 0;
`endif
        end
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic cycle(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [31:0] d1,
                         output int win);
        logic        ewe;
        logic [AW-1:0] ea;
        logic [31:0] ed;
        resp_t       e;
        @(negedge clk);
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        #1;
        win = pick(r0, r1);
        ewe = 1'b0; ea = '0; ed = '0;
        if (win == 0) begin ewe = w0; ea = a0; ed = d0; end
        if (win == 1) begin ewe = w1; ea = a1; ed = d1; end
        chk("p0_gnt", p0_gnt, (win == 0));
        chk("p1_gnt", p1_gnt, (win == 1));
        chk("mem_we", mem_we, ewe);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ed);
        if (win >= 0) begin
            if (ewe) begin
                shadow[ea] = ed;
            end else begin
                e.port = win; e.data = shadow[ea]; e.due = cyc + 1;
                q.push_back(e);
            end
            m_last = win;
        end
        if (r1 && win != 1) m_denied = (m_denied < MW) ? m_denied + 1 : MW;
        else                m_denied = 0;
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        int w;
        for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, 0, '0, '0, w);
    endtask

    // Both ports read continuously; winners must follow the fixed pattern.
    task automatic run_both(input int n);
        int w, exp;
        for (int i = 0; i < n; i++) begin
            cycle(1, 0, AW'(i), '0, 1, 0, AW'(i + 8), '0, w);
`ifdef DMEM_ARB_RR_EN
            exp = i % 2;
`else
            exp = ((i % (MW + 1)) == MW) ? 1 : 0;
`endif
            chk("both_pattern", w, exp);
        end
    endtask

    // Monitor: outputs are registered w.r.t. the requests, so sample at negedge.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (!p0_rvalid) chk("p0_rdata_idle", p0_rdata, '0);
            if (!p1_rvalid) chk("p1_rdata_idle", p1_rdata, '0);
            if (p0_rvalid || p1_rvalid) begin
                chk("rvalid_expected", (q.size() != 0), 1);
                chk("rvalid_one_port", (p0_rvalid && p1_rvalid), 0);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("rvalid_latency", cyc, e.due);
                    chk("rvalid_port", p1_rvalid, e.port);
                    chk("rdata", p1_rvalid ? p1_rdata : p0_rdata, e.data);
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                chk("rvalid_missing", (p0_rvalid || p1_rvalid), 1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic pr0, pw0, pr1, pw1;
        logic [AW-1:0] pa0, pa1;
        logic [31:0] pd0, pd1;

        rst_n = 1'b0; preload = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        for (int i = 0; i < 32; i++) shadow[i] = init_word(i);
        m_denied = 0; m_last = 1;

        #1;
        chk("rst_p0_gnt", p0_gnt, 0);
        chk("rst_p1_gnt", p1_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_p0_rvalid", p0_rvalid, 0);
        chk("rst_p1_rvalid", p1_rvalid, 0);
        chk("rst_p0_rdata", p0_rdata, '0);
        chk("rst_p1_rdata", p1_rdata, '0);

        repeat (2) @(posedge clk);
        preload = 1'b0;
        #2 rst_n = 1'b1;

        // Contention straight out of reset.
        run_both(10);
        idle(2);

        // Write then read the same word.
        cycle(1, 1, 5'd3, 32'hDEADBEEF, 0, 0, '0, '0, w);
        cycle(1, 0, 5'd3, '0, 0, 0, '0, '0, w);
        idle(2);

        // Port 1 alone reads preloaded word 7.
        cycle(0, 0, '0, '0, 1, 0, 5'd7, '0, w);
        idle(2);

        // Alternating single-port reads, one per cycle.
        cycle(1, 0, 5'd1, '0, 0, 0, '0, '0, w);
        cycle(0, 0, '0, '0, 1, 0, 5'd2, '0, w);
        cycle(1, 0, 5'd1, '0, 0, 0, '0, '0, w);
        cycle(0, 0, '0, '0, 1, 0, 5'd2, '0, w);

        // Read followed by a write to the same word: read sees old data.
        cycle(1, 0, 5'd4, '0, 0, 0, '0, '0, w);
        cycle(0, 0, '0, '0, 1, 1, 5'd4, 32'hCAFEF00D, w);
        cycle(1, 0, 5'd4, '0, 0, 0, '0, '0, w);
        idle(2);

        // Reset with a read in flight and port 1 partly starved.
        repeat (3) cycle(1, 0, 5'd5, '0, 1, 0, 5'd6, '0, w);
        #2 rst_n = 1'b0;
        q.delete();
        #1 chk("reset_drops_rvalid", p0_rvalid, 0);
        repeat (3) begin @(posedge clk); cyc++; end
        #2;
        m_denied = 0; m_last = 1;
        rst_n = 1'b1;
        run_both(10);
        idle(2);

        // Random traffic honouring the hold-until-grant rule.
        pr0 = 0; pw0 = 0; pa0 = '0; pd0 = '0;
        pr1 = 0; pw1 = 0; pa1 = '0; pd1 = '0;
        for (int n = 0; n < 400; n++) begin
            if (!pr0) begin
                if ($urandom_range(0, 9) < 6) begin
                    pr0 = 1; pw0 = 1'($urandom_range(0, 1));
                    pa0 = AW'($urandom_range(0, 7)); pd0 = $urandom;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                pr0 = 0;
            end
            if (!pr1) begin
                if ($urandom_range(0, 9) < 6) begin
                    pr1 = 1; pw1 = 1'($urandom_range(0, 1));
                    pa1 = AW'($urandom_range(0, 7)); pd1 = $urandom;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                pr1 = 0;
            end
            cycle(pr0, pw0, pa0, pd0, pr1, pw1, pa1, pd1, w);
            if (w == 0) pr0 = 0;
            if (w == 1) pr1 = 0;
        end
        idle(3);
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
